// File: rtl/hashcore_pkg.sv
// rtl/hashcore_pkg.sv - shared widths and sweep state encoding for the hash core sweeper
package hashcore_pkg;
  localparam int NONCE_W    = 32;
  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 96;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;
endpackage

// File: rtl/gn_fifo.sv
// rtl/gn_fifo.sv - golden-nonce FIFO with registered head and drop-on-full reporting
module gn_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_inc;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full, empty, do_push, do_pop;

  // Next storage, pointers, occupancy and head; a pop frees a slot for a same-cycle push.
  always_comb begin
    full       = (count_q == (AW+1)'(DEPTH));
    empty      = (count_q == '0);
    do_pop     = ~empty & pop_ready;
    do_push    = push & (~full | do_pop);
    drop       = push & full & ~do_pop;
    rd_ptr_inc = rd_ptr_q + AW'(1);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_inc;
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    head_d  = head_q;
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_pop) begin
      head_d = (count_q == (AW+1)'(1)) ? push_data : mem_q[rd_ptr_inc];
    end else if (empty) begin
      head_d = push_data;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = ~empty;
endmodule

// File: rtl/hashcore_sweep.sv
// rtl/hashcore_sweep.sv - bounded nonce sweep for one hash core with in-flight tracking and golden-nonce FIFO
module hashcore_sweep
  import hashcore_pkg::*;
#(
  parameter int PREFIX_BITS  = 2,
  parameter int PIPE_LATENCY = 65,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             hash_clk,
  input  logic                             hash_rst_n,
  input  logic                             work_load,
  input  logic [MIDSTATE_W-1:0]            midstate_in,
  input  logic [DATA_W-1:0]                data_in,
  input  logic [PREFIX_BITS-1:0]           nonce_prefix,
  input  logic [NONCE_W-PREFIX_BITS-1:0]   range_start,
  input  logic [NONCE_W-PREFIX_BITS-1:0]   range_end,
  output logic [MIDSTATE_W-1:0]            midstate,
  output logic [DATA_W-1:0]                data,
  output logic [NONCE_W-1:0]               nonce,
  input  logic                             gn_match,
  output logic                             gn_valid,
  input  logic                             gn_ready,
  output logic [NONCE_W-1:0]               golden_nonce,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow
);
  localparam int CW = NONCE_W - PREFIX_BITS;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d, tail_q, tail_d, range_end_q, range_end_d;
  logic [PREFIX_BITS-1:0]  prefix_q, prefix_d;
  logic [MIDSTATE_W-1:0]   midstate_q, midstate_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [PIPE_LATENCY-1:0] vld_q, vld_d, vld_shift;
  logic                    overflow_q, overflow_d;
  logic                    vld_out, match_push, fifo_drop;

  // The slot leaving the valid shift register is the result the core presents this cycle.
  assign vld_out    = vld_q[PIPE_LATENCY-1];
  assign match_push = gn_match & vld_out;

  // Sweep FSM, counters and valid tracking; a work load overrides everything else.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    range_end_d = range_end_q;
    prefix_d    = prefix_q;
    midstate_d  = midstate_q;
    data_d      = data_q;
    vld_shift   = (vld_q << 1) | PIPE_LATENCY'(state_q == RUN);
    vld_d       = vld_shift;
    tail_d      = vld_out ? tail_q + CW'(1) : tail_q;
    overflow_d  = overflow_q | fifo_drop;
    case (state_q)
      RUN: begin
        if (cnt_q == range_end_q) state_d = DRAIN;
        else                      cnt_d   = cnt_q + CW'(1);
      end
      DRAIN: begin
        if (vld_shift == '0) state_d = DONE;
      end
      default: ;
    endcase
    if (work_load) begin
      state_d     = RUN;
      cnt_d       = range_start;
      tail_d      = range_start;
      range_end_d = range_end;
      prefix_d    = nonce_prefix;
      midstate_d  = midstate_in;
      data_d      = data_in;
      vld_d       = '0;
      overflow_d  = 1'b0;
    end
  end

  // Sweep state registers.
  always_ff @(posedge hash_clk or negedge hash_rst_n) begin
    if (!hash_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tail_q      <= '0;
      range_end_q <= '0;
      prefix_q    <= '0;
      midstate_q  <= '0;
      data_q      <= '0;
      vld_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tail_q      <= tail_d;
      range_end_q <= range_end_d;
      prefix_q    <= prefix_d;
      midstate_q  <= midstate_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      overflow_q  <= overflow_d;
    end
  end

  gn_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_gn_fifo (
    .clk        (hash_clk),
    .rst_n      (hash_rst_n),
    .push       (match_push),
    .push_data  ({prefix_q, tail_q}),
    .pop_ready  (gn_ready),
    .head_data  (golden_nonce),
    .head_valid (gn_valid),
    .drop       (fifo_drop)
  );

  assign midstate = midstate_q;
  assign data     = data_q;
  assign nonce    = {prefix_q, cnt_q};
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign overflow = overflow_q;
endmodule

// File: tb/tb_hashcore_sweep.sv
// tb/tb_hashcore_sweep.sv - scoreboard bench for hashcore_sweep with a delay-line model of the hash core
module tb_hashcore_sweep;
  localparam int PB  = 2;
  localparam int LAT = 65;
  localparam int FD  = 4;

  logic         hash_clk = 1'b0;
  logic         hash_rst_n = 1'b0;
  logic         work_load = 1'b0;
  logic [255:0] midstate_in = '0;
  logic [95:0]  data_in = '0;
  logic [1:0]   nonce_prefix = '0;
  logic [29:0]  range_start = '0;
  logic [29:0]  range_end = '0;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic [31:0]  nonce;
  logic         gn_match = 1'b0;
  logic         gn_valid;
  logic         gn_ready = 1'b0;
  logic [31:0]  golden_nonce;
  logic         busy, done, overflow;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] match_set[$];
  logic [31:0] hist [0:LAT];
  logic [31:0] mon_exp;

  always #5 hash_clk = ~hash_clk;

  hashcore_sweep #(
    .PREFIX_BITS  (PB),
    .PIPE_LATENCY (LAT),
    .FIFO_DEPTH   (FD)
  ) dut (
    .hash_clk     (hash_clk),
    .hash_rst_n   (hash_rst_n),
    .work_load    (work_load),
    .midstate_in  (midstate_in),
    .data_in      (data_in),
    .nonce_prefix (nonce_prefix),
    .range_start  (range_start),
    .range_end    (range_end),
    .midstate     (midstate),
    .data         (data),
    .nonce        (nonce),
    .gn_match     (gn_match),
    .gn_valid     (gn_valid),
    .gn_ready     (gn_ready),
    .golden_nonce (golden_nonce),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  function automatic bit in_set(input logic [31:0] n);
    foreach (match_set[i]) if (match_set[i] == n) return 1'b1;
    return 1'b0;
  endfunction

  // Hash core model: flags a match LAT cycles after a listed nonce was presented.
  always @(negedge hash_clk) begin
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = nonce;
    gn_match = in_set(hist[LAT]);
  end

  // Scoreboard: every accepted FIFO head must be the next expected golden nonce.
  always @(negedge hash_clk) begin
    if (hash_rst_n && gn_valid && gn_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: golden_nonce=%h, none expected", golden_nonce);
      end else begin
        mon_exp = exp_q.pop_front();
        if (golden_nonce !== mon_exp) begin
          n_fail++;
          $display("FAIL pop_order: golden_nonce=%h want %h", golden_nonce, mon_exp);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge hash_clk);
      #1;
    end
  endtask

  task automatic load_work(input logic [255:0] ms, input logic [95:0] dt, input logic [1:0] pf,
                           input logic [29:0] s, input logic [29:0] e);
    midstate_in  = ms;
    data_in      = dt;
    nonce_prefix = pf;
    range_start  = s;
    range_end    = e;
    work_load    = 1'b1;
    step(1);
    work_load    = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      step(1);
      cyc++;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i <= LAT; i++) hist[i] = '0;
    step(2);
    n_checks++;
    if ({busy, done, overflow, gn_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, overflow, gn_valid});
    end
    n_checks++;
    if (nonce !== 32'h0 || golden_nonce !== 32'h0) begin
      n_fail++; $display("FAIL reset_nonce: got %h/%h want 0/0", nonce, golden_nonce);
    end
    n_checks++;
    if (midstate !== 256'h0 || data !== 96'h0) begin
      n_fail++; $display("FAIL reset_work: got %h/%h want 0/0", midstate[31:0], data[31:0]);
    end
    hash_rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_genesis;
    int cyc;
    gn_ready = 1'b1;
    match_set.delete(); match_set.push_back(32'h3fbd9207);
    exp_q.push_back(32'h3fbd9207);
    load_work({8{32'ha5a50001}}, 96'h0123456789abcdef01234567, 2'd0, 30'h3fbd9200, 30'h3fbd9210);
    n_checks++;
    if (busy !== 1'b1 || nonce !== 32'h3fbd9200) begin
      n_fail++; $display("FAIL genesis_start: busy=%b nonce=%h want 1/3fbd9200", busy, nonce);
    end
    n_checks++;
    if (midstate !== {8{32'ha5a50001}} || data !== 96'h0123456789abcdef01234567) begin
      n_fail++; $display("FAIL genesis_work: got %h/%h", midstate[31:0], data[31:0]);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 82 || busy !== 1'b0) begin
      n_fail++; $display("FAIL genesis_done: cycles=%0d busy=%b want 82/0", cyc, busy);
    end
    step(3);
    n_checks++;
    if (exp_q.size() !== 0 || gn_valid !== 1'b0) begin
      n_fail++; $display("FAIL genesis_drain: pending=%0d gn_valid=%b want 0/0", exp_q.size(), gn_valid);
    end
  endtask

  task automatic test_stale;
    int cyc;
    match_set.delete(); match_set.push_back(32'h1005); match_set.push_back(32'h105);
    exp_q.push_back(32'h105);
    load_work({8{32'h11111111}}, 96'h1, 2'd0, 30'h1000, 30'h1fff);
    step(29);
    load_work({8{32'h22222222}}, 96'h2, 2'd0, 30'h100, 30'h10f);
    n_checks++;
    if (nonce !== 32'h100 || midstate !== {8{32'h22222222}}) begin
      n_fail++; $display("FAIL stale_reload: nonce=%h want 00000100", nonce);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 81) begin
      n_fail++; $display("FAIL stale_done: cycles=%0d want 81", cyc);
    end
    step(3);
    n_checks++;
    if (exp_q.size() !== 0 || gn_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL stale_drain: pending=%0d gn_valid=%b overflow=%b want 0/0/0",
                         exp_q.size(), gn_valid, overflow);
    end
  endtask

  task automatic test_wrap;
    int cyc;
    logic [31:0] seq [5];
    seq = '{32'h7ffffffe, 32'h7fffffff, 32'h40000000, 32'h40000001, 32'h40000001};
    match_set.delete(); match_set.push_back(32'h40000000);
    exp_q.push_back(32'h40000000);
    load_work({8{32'h33333333}}, 96'h3, 2'd1, 30'h3ffffffe, 30'h1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (nonce !== seq[i] || busy !== 1'b1) begin
        n_fail++; $display("FAIL wrap_seq%0d: nonce=%h busy=%b want %h/1", i, nonce, busy, seq[i]);
      end
      step(1);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 64) begin
      n_fail++; $display("FAIL wrap_done: cycles=%0d want 64", cyc);
    end
    step(3);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL wrap_drain: pending=%0d want 0", exp_q.size());
    end
  endtask

  task automatic test_single;
    int cyc;
    match_set.delete(); match_set.push_back(32'h42);
    exp_q.push_back(32'h42);
    load_work({8{32'h44444444}}, 96'h4, 2'd0, 30'h42, 30'h42);
    wait_done(cyc);
    n_checks++;
    if (cyc !== LAT + 1) begin
      n_fail++; $display("FAIL single_done: cycles=%0d want %0d", cyc, LAT + 1);
    end
    step(3);
    n_checks++;
    if (exp_q.size() !== 0 || gn_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: pending=%0d gn_valid=%b want 0/0", exp_q.size(), gn_valid);
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    gn_ready = 1'b0;
    match_set.delete();
    for (int i = 0; i < 5; i++) match_set.push_back(32'h200 + i);
    for (int i = 0; i < FD; i++) exp_q.push_back(32'h200 + i);
    load_work({8{32'h55555555}}, 96'h5, 2'd0, 30'h200, 30'h20f);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 81) begin
      n_fail++; $display("FAIL bp_done: cycles=%0d want 81", cyc);
    end
    n_checks++;
    if (overflow !== 1'b1 || gn_valid !== 1'b1 || golden_nonce !== 32'h200) begin
      n_fail++; $display("FAIL bp_full: overflow=%b gn_valid=%b head=%h want 1/1/00000200",
                         overflow, gn_valid, golden_nonce);
    end
    match_set.delete(); match_set.push_back(32'h300);
    exp_q.push_back(32'h300);
    load_work({8{32'h66666666}}, 96'h6, 2'd0, 30'h300, 30'h300);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL bp_load_clear: overflow=%b want 0", overflow);
    end
    step(LAT);
    gn_ready = 1'b1;
    step(1);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL bp_push_pop_full: overflow=%b want 0", overflow);
    end
    step(10);
    n_checks++;
    if (exp_q.size() !== 0 || gn_valid !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: pending=%0d gn_valid=%b overflow=%b want 0/0/0",
                         exp_q.size(), gn_valid, overflow);
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    gn_ready = 1'b0;
    match_set.delete(); match_set.push_back(32'h500); match_set.push_back(32'h501);
    load_work({8{32'h77777777}}, 96'h7, 2'd0, 30'h500, 30'h5ff);
    step(LAT + 5);
    n_checks++;
    if (gn_valid !== 1'b1 || golden_nonce !== 32'h500 || busy !== 1'b1) begin
      n_fail++; $display("FAIL arst_before: gn_valid=%b head=%h busy=%b want 1/00000500/1",
                         gn_valid, golden_nonce, busy);
    end
    #2;
    hash_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, overflow, gn_valid} !== 4'b0 || nonce !== 32'h0 || golden_nonce !== 32'h0) begin
      n_fail++; $display("FAIL arst_outputs: flags=%b nonce=%h head=%h want 0000/0/0",
                         {busy, done, overflow, gn_valid}, nonce, golden_nonce);
    end
    n_checks++;
    if (midstate !== 256'h0 || data !== 96'h0) begin
      n_fail++; $display("FAIL arst_work: got %h/%h want 0/0", midstate[31:0], data[31:0]);
    end
    step(2);
    hash_rst_n = 1'b1;
    step(1);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || gn_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_idle: busy=%b done=%b gn_valid=%b want 0/0/0", busy, done, gn_valid);
    end
    gn_ready = 1'b1;
    match_set.delete(); match_set.push_back(32'h601);
    exp_q.push_back(32'h601);
    load_work({8{32'h88888888}}, 96'h8, 2'd0, 30'h600, 30'h601);
    wait_done(cyc);
    n_checks++;
    if (cyc !== LAT + 2) begin
      n_fail++; $display("FAIL arst_resume_done: cycles=%0d want %0d", cyc, LAT + 2);
    end
    step(3);
    n_checks++;
    if (exp_q.size() !== 0 || gn_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_resume_drain: pending=%0d gn_valid=%b want 0/0", exp_q.size(), gn_valid);
    end
  endtask

  initial begin
    test_reset();
    test_genesis();
    test_stale();
    test_wrap();
    test_single();
    test_backpressure();
    test_async_reset();
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hashcore_sweep.md
Name: hashcore_sweep

Overview:
- Parametrised successor to the single-core nonce sweeper; sits between the work/comms layer and one BLAKE hash pipeline instance (BLAKE_CORE_FOURP).
- Latches new work, drives a bounded nonce range into the core, and tracks in-flight nonces with a valid shift register, so a match maps exactly to its nonce.
- Discards results from stale work and queues golden nonces in a FIFO with a ready/valid handshake.

Parameters:
- PREFIX_BITS, 2: number of nonce MSBs fixed per core (multicore split); counter width CW = 32-PREFIX_BITS.
- PIPE_LATENCY, 65: cycles from nonce presented to core until its gn_match; must be at least 1.
- FIFO_DEPTH, 4: golden-nonce FIFO entries; power of 2, at least 2.

Ports:
- hash_clk  in  1  sole clock.
- hash_rst_n  in  1  asynchronous active-low reset.
- work_load  in  1  one-cycle strobe: latch new work and range.
- midstate_in  in  256  work midstate, sampled on work_load.
- data_in  in  96  work data tail, sampled on work_load.
- nonce_prefix  in  PREFIX_BITS  core prefix, sampled on work_load.
- range_start  in  CW  first counter value, sampled on work_load.
- range_end  in  CW  last counter value (inclusive), sampled on work_load.
- midstate  out  256  registered work to the core.
- data  out  96  registered work to the core.
- nonce  out  32  {prefix_r, cnt} to the core.
- gn_match  in  1  core match flag, aligned PIPE_LATENCY cycles after its nonce.
- gn_valid  out  1  FIFO head valid.
- gn_ready  in  1  consumer accepts head when gn_valid is also high.
- golden_nonce  out  32  FIFO head.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  level: range exhausted and pipeline drained.
- overflow  out  1  sticky: a match was dropped because the FIFO was full; cleared only by work_load or reset.

Behaviour:
- Reset values: all outputs 0, including midstate, data and nonce; cnt=0; tail=0; vld shift register all 0; FIFO empty; state IDLE.
- States:
  - IDLE: waits for work_load.
  - RUN: cnt increments by 1 each cycle. On the cycle cnt==range_end_r, issue the nonce and then go to DRAIN; cnt holds.
  - DRAIN: no new valid slots enter. When the vld register becomes all-zero, go to DONE.
  - DONE: done=1; waits for work_load.
- work_load, accepted in any state:
  - Next cycle: midstate/data/prefix_r/range_end_r hold the new values; cnt=range_start; tail=range_start; vld cleared to all 0; overflow cleared; state RUN.
  - FIFO contents are kept.
  - Results of the old work still in flight are discarded because their vld bits were cleared.
- Valid tracking: vld is a PIPE_LATENCY-bit shift register. Bit 0 takes 1 when in RUN, otherwise 0. The exiting bit, vld_out, qualifies gn_match.
- Tail: tail increments (mod 2^CW) whenever vld_out=1, so tail always equals the counter of the result emerging this cycle.
- Match: accepted only when gn_match & vld_out. Entry pushed is {prefix_r, tail}. No latency subtraction.
- Range edge cases:
  - range_start==range_end: exactly one nonce issued.
  - range_end<range_start: cnt wraps through 2^CW-1 to 0; the sweep stops at range_end.
  - Full range (start=0, end=2^CW-1): covers all 2^CW values once.
- FIFO:
  - A push when full with no simultaneous pop drops the entry and sets overflow.
  - Push and pop in the same cycle while full is legal: both occur, no overflow.
  - Pop requires gn_valid & gn_ready.
  - golden_nonce is registered FIFO head; entries are available the cycle after the push.
- Reset mid-operation: asynchronous return to reset values; no residual gn_valid.

Decomposition:
- Package hashcore_pkg: NONCE_W=32, MIDSTATE_W=256, DATA_W=96, state enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module gn_fifo (WIDTH, DEPTH): synchronous FIFO with push/pop, full/empty flags, and registered head output.

Test Plan:
- Genesis hit: PREFIX_BITS=2, prefix=0, start=0x3fbd9200, end=0x3fbd9210; model core flags match on nonce 0x3fbd9207 → exactly one entry golden_nonce=0x3fbd9207, then done=1 at 17+65 cycles after RUN entry, busy=0.
- Stale discard: load work A, 30 cycles later load work B with start=0x100; model asserts match for an A nonce issued before the reload → no FIFO push; a B match on 0x105 → golden_nonce=0x105.
- Wrap: start=0x3FFFFFFE, end=0x00000001 → nonces 0x3FFFFFFE, 0x3FFFFFFF, 0x0, 0x1 issued, then DRAIN; a match on 0x0 reports {prefix,0x0}.
- Single nonce: start=end=0x42 → one valid slot; done after PIPE_LATENCY+1 cycles; a match on that slot → 0x42.
- FIFO backpressure: gn_ready=0, matches on 5 consecutive nonces with FIFO_DEPTH=4 → 4 entries in order, overflow=1; with gn_ready=1 held while full plus a new match → no overflow, order preserved.
- Async reset mid-RUN with 2 entries queued → outputs 0 immediately, gn_valid=0, state IDLE; new work_load resumes normally.
